// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-requester RAM arbiter: default widths and
// requester index values used by the round-robin pointers.
package ram_arb_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 12;
  localparam int REQ_M0 = 0;
  localparam int REQ_M1 = 1;
endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester wins at once; on contention
// the pointer picks the winner, then moves to the loser after any grant.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic       r_ptr;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) w_gnt = r_ptr ? 2'b10 : 2'b01;
      else              w_gnt = req;
    end
  end

  // After a grant, the pointer names the requester that did not win.
  always_ff @(posedge clk) begin
    if (rst)         r_ptr <= 1'(REQ_M0);
    else if (|w_gnt) r_ptr <= w_gnt[REQ_M0];
  end

  assign gnt = w_gnt;
endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto a RAM with separate read and write ports.
// Handshake: a requester holds mX_req until mX_gnt=1 in the same cycle; reads
// return on mX_rvalid exactly one cycle after the grant, for one cycle.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_w_en,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_data,
  output logic          ram_r_en,
  output logic [AW-1:0] ram_r_addr,
  input  logic [DW-1:0] ram_r_data
);
  logic [1:0] w_rd_req, w_wr_req, w_rd_gnt, w_wr_gnt;
  logic [1:0] r_rd_sel;

  assign w_rd_req = {m1_req & ~m1_we, m0_req & ~m0_we};
  assign w_wr_req = {m1_req &  m1_we, m0_req &  m0_we};

  rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .req(w_rd_req), .gnt(w_rd_gnt));
  rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .req(w_wr_req), .gnt(w_wr_gnt));

  assign m0_gnt = w_rd_gnt[REQ_M0] | w_wr_gnt[REQ_M0];
  assign m1_gnt = w_rd_gnt[REQ_M1] | w_wr_gnt[REQ_M1];

  always_comb begin
    ram_w_en   = 1'b0;
    ram_w_addr = '0;
    ram_w_data = '0;
    if (w_wr_gnt[REQ_M0]) begin
      ram_w_en   = 1'b1;
      ram_w_addr = m0_addr;
      ram_w_data = m0_wdata;
    end else if (w_wr_gnt[REQ_M1]) begin
      ram_w_en   = 1'b1;
      ram_w_addr = m1_addr;
      ram_w_data = m1_wdata;
    end
  end

  always_comb begin
    ram_r_en   = 1'b0;
    ram_r_addr = '0;
    if (w_rd_gnt[REQ_M0]) begin
      ram_r_en   = 1'b1;
      ram_r_addr = m0_addr;
    end else if (w_rd_gnt[REQ_M1]) begin
      ram_r_en   = 1'b1;
      ram_r_addr = m1_addr;
    end
  end

  // Remember who owns the data the RAM returns next cycle.
  always_ff @(posedge clk) begin
    if (rst) r_rd_sel <= 2'b00;
    else     r_rd_sel <= w_rd_gnt;
  end

  assign m0_rvalid = r_rd_sel[REQ_M0];
  assign m1_rvalid = r_rd_sel[REQ_M1];
  assign m0_rdata  = m0_rvalid ? ram_r_data : '0;
  assign m1_rdata  = m1_rvalid ? ram_r_data : '0;
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, data width.
REQ-002 SHALL have parameter AW, default 12, word-address width.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have, for each requester m0 and m1, port mX_req  in  1  access request; held until granted.
REQ-006 SHALL have, per requester, port mX_we  in  1  1=write, 0=read.
REQ-007 SHALL have, per requester, port mX_addr  in  AW  word address.
REQ-008 SHALL have, per requester, port mX_wdata  in  DW  write data.
REQ-009 SHALL have, per requester, port mX_gnt  out  1  request accepted this cycle (combinational).
REQ-010 SHALL have, per requester, port mX_rvalid  out  1  read data valid.
REQ-011 SHALL have, per requester, port mX_rdata  out  DW  read data.
REQ-012 SHALL have ports ram_w_en out 1, ram_w_addr out AW, ram_w_data out DW: memory write port.
REQ-013 SHALL have ports ram_r_en out 1, ram_r_addr out AW: memory read port.
REQ-014 SHALL have port ram_r_data in DW: memory read data, one cycle after ram_r_en.

Function
REQ-015 SHALL arbitrate reads (req & ~we) and writes (req & we) independently; one read and one write may be granted in the same cycle.
REQ-016 SHALL grant a sole requester on a port immediately, regardless of pointer state.
REQ-017 SHALL resolve two simultaneous requesters on a port round-robin: grant the one named by that port's pointer.
REQ-018 SHALL set a port's pointer to the non-granted requester after every grant on that port; with no grant, the pointer holds.
REQ-019 SHALL drive ram_w_en=1, ram_w_addr and ram_w_data from the write winner in the grant cycle; otherwise ram_w_en=0 and addr/data=0.
REQ-020 SHALL drive ram_r_en=1 and ram_r_addr from the read winner in the grant cycle; otherwise ram_r_en=0 and ram_r_addr=0.
REQ-021 SHALL register the read winner's identity, giving read latency exactly 1: grant at cycle N -> mX_rvalid=1 and mX_rdata=ram_r_data at cycle N+1, for one cycle.
REQ-022 SHALL drive mX_rdata=0 whenever mX_rvalid=0.
REQ-023 SHALL sustain back-to-back reads: one read grant per cycle, rvalid every cycle, alternating between requesters under contention.
REQ-024 SHALL pass through a same-cycle read and write to the same address unmodified; memory bypass returns the new data.
REQ-025 SHALL drive mX_gnt=0 for a deasserted mX_req; an ungranted requester sees no side effects.

Reset
REQ-026 SHALL, while rst=1, force all mX_gnt, ram_w_en and ram_r_en to 0.
REQ-027 SHALL reset both pointers to m0 and the registered rvalid state to 0, so all mX_rvalid=0 in the cycle after rst.
REQ-028 SHALL discard any read granted in the cycle rst rises: no rvalid follows it.

Structure
REQ-029 SHALL place DW/AW defaults and requester index constants (REQ_M0=0, REQ_M1=1) in shared package ram_arb_pkg.
REQ-030 SHALL implement the 2-way round-robin as sub-module rr_arb2 (req[1:0] -> gnt[1:0], internal pointer), instantiated once for reads and once for writes.

Verification
REQ-031 SHALL test: m0 read addr 0x010, memory word 0xDEADBEEF -> m0_gnt in cycle N; m0_rvalid=1, m0_rdata=0xDEADBEEF in N+1; m1_rvalid=0.
REQ-032 SHALL test: after reset, m0 and m1 both read continuously for 4 cycles -> grants m0,m1,m0,m1; rvalid follows one cycle later on the matching requester.
REQ-033 SHALL test: m0 writes 0x5 to 0x020 while m1 reads 0x030 -> both granted in the same cycle; ram_w_en=1 and ram_r_en=1.
REQ-034 SHALL test: m1 writes 0xA5A5A5A5 to 0x040 while m0 reads 0x040 in the same cycle -> m0_rdata=0xA5A5A5A5 next cycle.
REQ-035 SHALL test: rst asserted in the cycle of an m1 read grant -> m1_rvalid=0 next cycle; next contended write grants m0.
REQ-036 SHALL test: only m1 requests reads for 3 cycles while the pointer is at m0 -> m1 granted every cycle with no idle cycles.
